// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative radix-2^k multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic             neg;
    logic [MAX_W-1:0] mag;
  } abs_t;

  function automatic int cnt_w(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  // v holds a w-bit value zero-extended; the most negative input maps to 2^(w-1).
  function automatic abs_t abs_w(input logic [MAX_W-1:0] v, input int w, input logic sgn);
    abs_t             r;
    logic [MAX_W-1:0] mask;
    logic             sbit;
    mask  = (MAX_W'(1) << w) - MAX_W'(1);
    sbit  = |(v & (MAX_W'(1) << (w - 1)));
    r.neg = sgn & sbit;
    r.mag = r.neg ? ((~v + MAX_W'(1)) & mask) : (v & mask);
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_pp_step.sv
// One digit of partial product: acc_o = acc_i + (mcand_i * digit_i) << shift_i.
module seq_mult_pp_step #(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1,
  parameter int AW         = 2*WIDTH + RADIX_BITS,
  parameter int SW         = $clog2(WIDTH) + 1
) (
  input  logic [AW-1:0]         acc_i,
  input  logic [WIDTH-1:0]      mcand_i,
  input  logic [RADIX_BITS-1:0] digit_i,
  input  logic [SW-1:0]         shift_i,
  output logic [AW-1:0]         acc_o
);

  localparam int PW = WIDTH + RADIX_BITS;

  logic [RADIX_BITS-1:0][PW-1:0] pp_rows;
  logic [PW-1:0]                 pp_sum;

  for (genvar j = 0; j < RADIX_BITS; j++) begin : g_row
    assign pp_rows[j] = digit_i[j] ? (PW'(mcand_i) << j) : '0;
  end

  // mcand * (2^R - 1) < 2^(WIDTH+R), so the row sum never wraps in PW bits.
  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < RADIX_BITS; j++) pp_sum = pp_sum + pp_rows[j];
  end

  assign acc_o = acc_i + (AW'(pp_sum) << shift_i);

endmodule

// File: rtl/seq_mult_radix.sv
// Iterative signed/unsigned multiplier retiring RADIX_BITS multiplier bits per clock.
module seq_mult_radix
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER = WIDTH / RADIX_BITS;
  localparam int CW   = cnt_w(ITER);
  localparam int AW   = 2*WIDTH + RADIX_BITS;
  localparam int SW   = $clog2(WIDTH) + 1;

  if (WIDTH < 2 || RADIX_BITS < 1 || (WIDTH % RADIX_BITS) != 0 || WIDTH > MAX_W) begin : g_bad_cfg
    $error("seq_mult_radix: WIDTH must be >=2, <=64 and a multiple of RADIX_BITS");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   bmag_q,  bmag_d;
  logic               neg_q,   neg_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic [SW-1:0]      shift_q, shift_d;
  logic [AW-1:0]      acc_q,   acc_d;
  logic [2*WIDTH-1:0] prod_q,  prod_d;

  abs_t               a_abs, b_abs;
  logic [AW-1:0]      acc_step;
  logic               unused_abs;

  assign a_abs      = abs_w(MAX_W'(a), WIDTH, is_signed);
  assign b_abs      = abs_w(MAX_W'(b), WIDTH, is_signed);
  assign unused_abs = ^{a_abs.mag, b_abs.mag};

  seq_mult_pp_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS),
    .AW         (AW),
    .SW         (SW)
  ) u_pp_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (bmag_q[RADIX_BITS-1:0]),
    .shift_i (shift_q),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    bmag_d  = bmag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        // abort beats a simultaneous start
        if (start && !abort) begin
          state_d = ST_RUN;
          mcand_d = a_abs.mag[WIDTH-1:0];
          bmag_d  = b_abs.mag[WIDTH-1:0];
          neg_d   = a_abs.neg ^ b_abs.neg;
          acc_d   = '0;
          cnt_d   = CW'(ITER - 1);
          shift_d = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = acc_step;
          bmag_d  = bmag_q >> RADIX_BITS;
          shift_d = shift_q + SW'(RADIX_BITS);
          if (cnt_q == '0) state_d = ST_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_FIX: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          prod_d  = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      bmag_q  <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      bmag_q  <= bmag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_radix.sv
// Directed and random checks of seq_mult_radix at radix 2, 4 and 16 (WIDTH=8).
module tb_seq_mult_radix;

  localparam int W  = 8;
  localparam int NR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    a, b;
  logic            is_signed;
  logic [NR-1:0]   start, abort, busy, done;
  logic [2*W-1:0]  prod0, prod1, prod2;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
    string          tag;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_radix #(.WIDTH(W), .RADIX_BITS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .is_signed(is_signed), .abort(abort[0]),
    .a(a), .b(b), .busy(busy[0]), .done(done[0]), .product(prod0));
  seq_mult_radix #(.WIDTH(W), .RADIX_BITS(2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .is_signed(is_signed), .abort(abort[1]),
    .a(a), .b(b), .busy(busy[1]), .done(done[1]), .product(prod1));
  seq_mult_radix #(.WIDTH(W), .RADIX_BITS(4)) u_r4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .is_signed(is_signed), .abort(abort[2]),
    .a(a), .b(b), .busy(busy[2]), .done(done[2]), .product(prod2));

  function automatic int iter_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 2;
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    logic signed [2*W-1:0] sx, sy;
    if (s) begin
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int k, input logic [2*W-1:0] p, input int due, input string tag);
    exp_t e;
    e.p = p; e.due = due; e.tag = tag;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int k, input logic [2*W-1:0] p);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    chk($sformatf("r%0d_unexpected_done", k), 32'(n != 0), 32'd1);
    if (n != 0) begin
      case (k)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("r%0d_%s_product", k, e.tag), 32'(p), 32'(e.p));
      chk($sformatf("r%0d_%s_latency", k, e.tag), 32'(cyc), 32'(e.due));
    end
  endtask

  // Scoreboard drain on each done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (done[0]) mon(0, prod0);
    if (done[1]) mon(1, prod1);
    if (done[2]) mon(2, prod2);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [NR-1:0] mask, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input string tag);
    a = x; b = y; is_signed = s;
    for (int k = 0; k < NR; k++)
      if (mask[k]) push(k, ref_mul(x, y, s), cyc + iter_of(k) + 2, tag);
    start = mask;
    tick(1);
    start = '0;
  endtask

  task automatic wait_idle(input int budget = 40);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    q0.delete(); q1.delete(); q2.delete();
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rx, ry;
    logic         rs;
    int           d1;

    rst_n = 1'b1; start = '0; abort = '0; a = '0; b = '0; is_signed = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_prod0", 32'(prod0), 32'd0);
    chk("reset_prod2", 32'(prod2), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    issue(3'b111, 8'd5,   8'd3,   1'b0, "u5x3");      wait_idle();
    issue(3'b111, 8'd255, 8'd255, 1'b0, "u255x255");  wait_idle();
    issue(3'b111, 8'd10,  8'd0,   1'b0, "u10x0");     wait_idle();
    issue(3'b111, 8'hFD,  8'h05,  1'b1, "s_m3x5");    wait_idle();
    issue(3'b111, 8'h80,  8'h80,  1'b1, "s_m128sq");  wait_idle();
    issue(3'b111, 8'h80,  8'h7F,  1'b1, "s_m128x127"); wait_idle();
    issue(3'b111, 8'hFD,  8'h05,  1'b0, "u253x5");    wait_idle();
    issue(3'b111, 8'd200, 8'd173, 1'b0, "u200x173");  wait_idle();

    // start with new operands during RUN cycle 3 must be ignored
    issue(3'b001, 8'd5, 8'd3, 1'b0, "busy_ignore");
    tick(2);
    a = 8'd7; b = 8'd9; is_signed = 1'b1; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    wait_idle();

    // start held through DONE: second op starts on the DONE edge
    a = 8'd12; b = 8'd11; is_signed = 1'b0; start[0] = 1'b1;
    d1 = cyc + iter_of(0) + 2;
    push(0, 16'd132, d1, "b2b_first");
    tick(1);
    a = 8'hFA; b = 8'd7; is_signed = 1'b1;
    push(0, 16'hFFD6, d1 + iter_of(0) + 2, "b2b_second");
    while (cyc < d1 + 1) tick(1);
    start[0] = 1'b0;
    wait_idle();

    // abort in RUN cycle 4: no done, product unchanged
    issue(3'b001, 8'd5, 8'd3, 1'b0, "pre_abort"); wait_idle();
    a = 8'd9; b = 8'd9; is_signed = 1'b0; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(3);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_run_busy", 32'(busy[0]), 32'd0);
    chk("abort_run_done", 32'(done[0]), 32'd0);
    chk("abort_run_prod", 32'(prod0), 32'd15);
    tick(12);
    chk("abort_run_prod_later", 32'(prod0), 32'd15);

    // abort while in FIX (radix-16 instance reaches FIX 3 edges after start)
    a = 8'd9; b = 8'd9; start[2] = 1'b1;
    tick(1);
    start[2] = 1'b0;
    tick(2);
    abort[2] = 1'b1;
    tick(1);
    abort[2] = 1'b0;
    @(negedge clk);
    chk("abort_fix_busy", 32'(busy[2]), 32'd0);
    chk("abort_fix_prod", 32'(prod2), 32'd34600);
    tick(4);

    // abort together with start in IDLE drops the start
    a = 8'd2; b = 8'd2; start[0] = 1'b1; abort[0] = 1'b1;
    tick(1);
    start[0] = 1'b0; abort[0] = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", 32'(busy[0]), 32'd0);
    tick(12);
    issue(3'b001, 8'd6, 8'd6, 1'b0, "post_abort"); wait_idle();

    // asynchronous reset mid-RUN, between clock edges
    a = 8'd13; b = 8'd13; start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy[0]), 32'd0);
    chk("async_rst_done", 32'(done[0]), 32'd0);
    chk("async_rst_prod", 32'(prod0), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("post_rst_idle", 32'(busy), 32'd0);
    issue(3'b111, 8'd3, 8'd4, 1'b0, "post_rst"); wait_idle();

    for (int i = 0; i < 1000; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      issue(3'b111, rx, ry, rs, "rand");
      wait_idle();
    end

    chk("final_queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_radix.md
Name: seq_mult_radix

Overview:
Parametrised iterative multiplier that retires RADIX_BITS multiplier bits per clock.
It supports unsigned and two's-complement signed operands, selected per operation, and provides a start/busy/done handshake with an abort.
It replaces the fixed radix-2, unsigned-only sequential multiplier in arithmetic datapaths where area matters more than throughput.

Parameters:
WIDTH, 8, operand width in bits (>=2)
RADIX_BITS, 1, multiplier bits consumed per iteration; WIDTH % RADIX_BITS must be 0 (elaboration error otherwise)
ITER, WIDTH/RADIX_BITS (localparam), iteration count

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
is_signed  input  1  1 = operands two's complement; sampled with start
abort  input  1  cancel operation in progress; no done produced
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  operation in progress; start is ignored while high
done  output  1  one-cycle pulse: product valid
product  output  2*WIDTH  result; held stable until the next done

Behaviour:
- Reset: the single clock is clk. Reset is asynchronous and active-low on rst_n, and forces state IDLE, busy=0, done=0, product=0, and clears the internal accumulator, counter and sign registers. A reset mid-operation discards the operation; no done follows.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE and start=1 at edge E0:
  - Latch |a| and |b| into WIDTH-bit magnitude registers. Magnitude is computed only when is_signed=1; the most negative value maps to 2^(WIDTH-1).
  - Latch neg = is_signed & (a[MSB] ^ b[MSB]).
  - Clear the accumulator and set counter=ITER-1.
  - Go to RUN; busy=1 from E0.
- RUN: at each edge, acc += mcand * b_mag[RADIX_BITS-1:0] shifted into position, then shift b_mag right by RADIX_BITS and decrement the counter. The accumulator is 2*WIDTH+RADIX_BITS bits internally, so no overflow can occur. Exit to FIX on the edge where counter==0, i.e. after exactly ITER RUN edges.
- FIX (one cycle): product <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0]. Go to DONE; done=1 and busy=0 from this edge.
- DONE: lasts one cycle. Then go to IDLE, or go directly to RUN if start=1 (back-to-back accepted, no bubble).
- Latency: done is high in the cycle after edge E0+ITER+1. Examples: WIDTH=8/RADIX_BITS=1 gives 9 edges; RADIX_BITS=2 gives 5 edges.
- start while busy: ignored, with no effect on the operands in flight.
- abort=1 in RUN or FIX: go to IDLE at the next edge with busy=0 and done=0; product keeps its previous value.
- abort together with start in IDLE: abort wins and the start is dropped.
- abort in IDLE or DONE: no effect beyond dropping a simultaneous start.
- The signed result is always exact in 2*WIDTH bits, including (-2^(W-1))^2.
- is_signed=0: operands are treated as plain unsigned; neg=0.

Decomposition:
- Package seq_mult_pkg holds:
  - the state enum (IDLE, RUN, FIX, DONE)
  - a function for counter width, clog2(ITER)
  - a helper function abs_w returning magnitude and sign
- One natural sub-module: seq_mult_pp_step. It is combinational and computes acc_next = acc + (mcand * digit) << shift for one RADIX_BITS digit. It is parametrised on WIDTH and RADIX_BITS so the top-level FSM stays radix-agnostic.

Test Plan:
- WIDTH=8, RADIX_BITS=1, unsigned: 5x3 -> product=15, done exactly 9 edges after start. 255x255 -> 65025. 10x0 -> 0.
- Signed mode, WIDTH=8: -3x5 (0xFD, 0x05) -> 0xFFF1. -128x-128 -> 16384 (0x4000). -128x127 -> 0xC080. Same 0xFD x 0x05 with is_signed=0 -> 1265.
- RADIX_BITS=2 and RADIX_BITS=4 builds: 200x173 -> 34600, done after ITER+1 edges (5 and 3 respectively). Random 1000-vector sweep against a reference model, both modes.
- Handshake: start=1 with new operands at cycle 3 of RUN -> ignored, result reflects the original operands. start held through DONE -> second operation begins with no idle cycle, and its done follows ITER+1 edges later.
- Abort: abort pulse in RUN cycle 4 -> busy drops next edge, no done pulse, product keeps its previous value (e.g. 15). A following start completes normally.
- Reset: rst_n low asynchronously mid-RUN -> busy, done and product read 0 immediately without a clock edge. No done appears after release until a new start.
